// File: rtl/plru_victim_sel.sv
// Tree pseudo-LRU replacement state for a set-associative cache: touch updates and victim selection.
// Optional build macro PLRU_INVALID_FIRST_EN: a victim request picks the lowest-index invalid way first.
module plru_victim_sel #(
    parameter int a_size = 8,
    parameter int sets   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_op,
    input  logic [$clog2(sets)-1:0]   req_set,
    input  logic [$clog2(a_size)-1:0] req_way,
    input  logic [a_size-1:0]         way_valid,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(a_size)-1:0] resp_way
);

    localparam int LW = $clog2(a_size);
    localparam int SW = $clog2(sets);

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        UPDATE,
        RESP
    } state_t;

    state_t          state_q;
    logic            op_q;
    logic [SW-1:0]   set_q;
    logic [LW-1:0]   way_q;
    logic [LW-1:0]   node_q;
    logic [LW-1:0]   lvl_q;

    // Node n lives at bit n; the top bit (index a_size-1) pads the vector to a power of two.
    logic [a_size-1:0] tree_q [sets];

    logic [a_size-1:0] cur_bits;
    logic [a_size-1:0] upd_bits;
    logic              dir;

    assign cur_bits = tree_q[set_q];
    assign dir      = ~cur_bits[node_q];

    // NOTE: every variable written here gets a value before any conditional use, so no latch is inferred.
    always_comb begin
        logic [LW-1:0] n;
        logic          b;
        upd_bits = cur_bits;
        n        = '0;
        b        = 1'b0;
        for (int l = 0; l < LW; l++) begin
            b           = way_q[LW-1-l];
            upd_bits[n] = b;
            n           = LW'(2 * int'(n) + 1 + int'(b));
        end
    end

`ifdef PLRU_INVALID_FIRST_EN
    logic          has_invalid;
    logic [LW-1:0] first_invalid;

    assign has_invalid = ~&way_valid;

    always_comb begin
        first_invalid = '0;
        for (int i = a_size - 1; i >= 0; i--) begin
            if (!way_valid[i]) first_invalid = LW'(i);
        end
    end
`else
    logic unused_way_valid;
    assign unused_way_valid = ^way_valid;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_way   <= '0;
            op_q       <= 1'b0;
            set_q      <= '0;
            way_q      <= '0;
            node_q     <= '0;
            lvl_q      <= '0;
            // NOTE: the tree array is reset because "all ways unused" (all zero) is the defined start state.
            for (int s = 0; s < sets; s++) tree_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        set_q     <= req_set;
                        node_q    <= '0;
                        lvl_q     <= '0;
                        if (!req_op) begin
                            way_q   <= req_way;
                            state_q <= UPDATE;
                        end else begin
`ifdef PLRU_INVALID_FIRST_EN
                            if (has_invalid) begin
                                way_q   <= first_invalid;
                                state_q <= UPDATE;
                            end else begin
                                state_q <= WALK;
                            end
`else
                            state_q <= WALK;
`endif
                        end
                    end
                end
                WALK: begin
                    // One tree level per cycle; the chosen direction is shifted in as the next way bit.
                    way_q  <= LW'({way_q, dir});
                    node_q <= LW'(2 * int'(node_q) + 1 + int'(dir));
                    lvl_q  <= lvl_q + 1'b1;
                    if (lvl_q == LW'(LW - 1)) state_q <= UPDATE;
                end
                UPDATE: begin
                    tree_q[set_q] <= upd_bits;
                    resp_valid    <= 1'b1;
                    resp_way      <= way_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plru_victim_sel.sv
// Directed bench for plru_victim_sel (a_size=8, sets=16); honours PLRU_INVALID_FIRST_EN if defined.
module tb_plru_victim_sel;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [3:0] req_set;
    logic [2:0] req_way;
    logic [7:0] way_valid;
    logic       resp_valid;
    logic       resp_ready;
    logic [2:0] resp_way;

    int checks = 0;
    int errors = 0;

    plru_victim_sel #(.a_size(8), .sets(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_set    (req_set),
        .req_way    (req_way),
        .way_valid  (way_valid),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_way   (resp_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait for its response, consume it; lat counts cycles from accept (-1 on timeout).
    task automatic do_req(input logic op, input logic [3:0] set, input logic [2:0] way,
                          input logic [7:0] wv, output logic [2:0] got, output int lat);
        int n;
        got = '0;
        lat = -1;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) return;
        req_valid = 1'b1;
        req_op    = op;
        req_set   = set;
        req_way   = way;
        way_valid = wv;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_set   = ~set;
        req_way   = ~way;
        way_valid = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        got        = resp_way;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        way_valid  = 8'hFF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++;
        if (resp_way !== 3'd0) begin errors++; $display("FAIL reset_resp_way got %0d want 0", resp_way); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_victim_seq();
        logic [2:0] w;
        int         lat;
        logic [2:0] exp_way [3] = '{3'd7, 3'd3, 3'd5};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 4'd0, 3'd0, 8'hFF, w, lat);
            checks++;
            if (w !== exp_way[i]) begin errors++; $display("FAIL victim%0d_way got %0d want %0d", i, w, exp_way[i]); end
            checks++;
            if (lat != 5) begin errors++; $display("FAIL victim%0d_latency got %0d want 5", i, lat); end
            if (i == 0) begin
                checks++;
                if (dut.tree_q[0][6:0] !== 7'b1000101) begin
                    errors++; $display("FAIL victim0_tree got %b want 1000101", dut.tree_q[0][6:0]);
                end
            end
        end
    endtask

    task automatic test_touch();
        logic [2:0] w;
        int         lat;
        do_req(1'b0, 4'd2, 3'd6, 8'hFF, w, lat);
        checks++;
        if (w !== 3'd6) begin errors++; $display("FAIL touch_way got %0d want 6", w); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL touch_latency got %0d want 2", lat); end
        do_req(1'b1, 4'd2, 3'd0, 8'hFF, w, lat);
        checks++;
        if (w !== 3'd3) begin errors++; $display("FAIL touch_then_victim_way got %0d want 3", w); end
        checks++;
        if (dut.tree_q[0][6:0] !== 7'b1110011) begin
            errors++; $display("FAIL other_set_tree got %b want 1110011", dut.tree_q[0][6:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] w;
        int         lat;
        int         n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_set   = 4'd4;
        way_valid = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout got %b want 1", resp_valid); end
        // A stray touch of way 0 on the same set must be ignored while the response is stalled.
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_way   = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_way !== 3'd7 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b way=%0d ready=%b want 1 7 0", c, resp_valid, resp_way, req_ready);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
        do_req(1'b1, 4'd4, 3'd0, 8'hFF, w, lat);
        checks++;
        if (w !== 3'd3) begin errors++; $display("FAIL bp_next_victim got %0d want 3", w); end
    endtask

    task automatic test_reset_mid_op();
        logic [2:0] w;
        int         lat;
        int         n;
        // Reset during WALK.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_set   = 4'd6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL walk_reset got valid=%b ready=%b want 0 0", resp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 4'd6, 3'd0, 8'hFF, w, lat);
        checks++;
        if (w !== 3'd7) begin errors++; $display("FAIL walk_reset_victim got %0d want 7", w); end
        // Reset while a response is pending drops it between clock edges.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_set   = 4'd6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_way !== 3'd0) begin
            errors++; $display("FAIL resp_reset got valid=%b way=%0d want 0 0", resp_valid, resp_way);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_invalid_first();
        logic [2:0] w;
        int         lat;
        do_req(1'b1, 4'd8, 3'd0, 8'b1111_1011, w, lat);
`ifdef PLRU_INVALID_FIRST_EN
        checks++;
        if (w !== 3'd2) begin errors++; $display("FAIL invalid_first_way got %0d want 2", w); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL invalid_first_latency got %0d want 2", lat); end
`else
        checks++;
        if (w !== 3'd7) begin errors++; $display("FAIL invalid_ignored_way got %0d want 7", w); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL invalid_ignored_latency got %0d want 5", lat); end
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_set    = '0;
        req_way    = '0;
        way_valid  = 8'hFF;
        resp_ready = 1'b0;
        test_reset();
        test_victim_seq();
        test_touch();
        test_backpressure();
        test_reset_mid_op();
        test_invalid_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
